// File: rtl/arb_types.sv
// Shared types for the I/D cache arbiter: FSM states, requester identity and
// the default line width.
package arb_types;

  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/arb_pick.sv
// Fairness policy: a lone requester wins outright; on a tie the requester
// that did not win last time is granted.
module arb_pick
  import arb_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output logic     grant_valid,
  output arb_src_t grant_src
);

  // NOTE: every output gets a default at the top of always_comb so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_src   = SRC_I;
    if (i_req && d_req) begin
      grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
    end else if (d_req) begin
      grant_src = SRC_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Serializes whole-line icache reads and dcache reads/writebacks onto the
// single cacheline-adaptor port, with alternating priority on ties.
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t        state_q;
  arb_src_t          last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic     d_req;
  logic     grant_valid;
  arb_src_t grant_src;
  logic     conflict;

  assign d_req = d_read | d_write;

  arb_pick u_pick (
    .i_req       (i_read),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_src;
            wdata_q      <= d_wdata;
            if (grant_src == SRC_I) begin
              state_q      <= SERVE_I;
              addr_q       <= i_address;
              pmem_read_q  <= 1'b1;
              pmem_write_q <= 1'b0;
            end else begin
              // A simultaneous read and writeback from the dcache is a writeback.
              state_q      <= SERVE_D;
              addr_q       <= d_address;
              pmem_read_q  <= ~d_write;
              pmem_write_q <= d_write;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign conflict = ((state_q == SERVE_I) && d_req) ||
                    ((state_q == SERVE_D) && i_read);

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign conflict_cnt = cnt_q;

  // Completion is combinational so the cache sees it in the adaptor's cycle.
  assign i_resp  = (state_q == SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read && pmem_write));
  a_resp_excl : assert property (@(posedge clk) disable iff (!rst)
    !(i_resp && d_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single requests, ties, alternation,
// input isolation after grant, reset abort and counter saturation.
module tb_cache_arbiter;
  import arb_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [15:0]   conflict_cnt;

  logic [LW-1:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
  logic          s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
  logic [AW-1:0] s_pmem_address;
  logic [3:0]    s_conflict_cnt;

  int total = 0;
  int bad = 0;
  int last_wait = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_cnt(conflict_cnt)
  );

  // Same traffic into a 4-bit counter instance to exercise saturation.
  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
    .pmem_wdata(s_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_cnt(s_conflict_cnt)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for a strobe, checks the granted transfer, answers after lat cycles,
  // checks the completion and the following idle cycle.
  task automatic serve(input bit exp_d, input bit exp_wr, input logic [AW-1:0] exp_addr,
                       input logic [LW-1:0] exp_wdata, input logic [LW-1:0] rdata,
                       input int lat, input bit drop, input bit scramble);
    int waited = 0;
    @(negedge clk);
    while (!(pmem_read || pmem_write) && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    last_wait = waited;
    if (waited >= 20) begin
      check("strobe_timeout", 1'b0, 1'b1);
      return;
    end
    check("pmem_write", pmem_write, exp_wr);
    check("pmem_read", pmem_read, !exp_wr);
    check("pmem_address", pmem_address, exp_addr);
    if (exp_wr) check("pmem_wdata", pmem_wdata, exp_wdata);
    repeat (lat) begin
      @(posedge clk); #1;
      if (scramble) begin
        d_address = 32'h0000_DEAD;
        d_wdata   = {LW{1'b1}};
      end
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    @(negedge clk);
    check("i_resp", i_resp, !exp_d);
    check("d_resp", d_resp, exp_d);
    check("rdata", exp_d ? d_rdata : i_rdata, rdata);
    if (scramble) check("addr_held", pmem_address, exp_addr);
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (drop) begin
      if (exp_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
    @(negedge clk);
    check("gap_strobes", {pmem_read, pmem_write}, 2'b00);
    check("gap_resp", {i_resp, d_resp}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_1234;
    int waited;
    line_a5   = {32{8'hA5}};
    line_1234 = {16{16'h1234}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    check("rst_state", dut.state_q, IDLE);
    check("rst_addr", pmem_address, 32'h0);
    check("rst_wdata", pmem_wdata, '0);
    check("rst_cnt", conflict_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Lone icache read, memory answers after 5 cycles
    @(posedge clk); #1;
    i_read    = 1'b1;
    i_address = 32'h0000_0060;
    serve(1'b0, 1'b0, 32'h0000_0060, '0, line_a5, 5, 1'b1, 1'b0);
    check("t1_latency", last_wait, 1);
    check("t1_cnt", conflict_cnt, 16'd0);

    // Tie after an I grant: D writeback first, then I
    i_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0100;
    d_wdata   = line_1234;
    serve(1'b1, 1'b1, 32'h0000_0100, line_1234, {32{8'h11}}, 3, 1'b1, 1'b0);
    check("t2_cnt_d", conflict_cnt, 16'd4);
    check("t2_sat_d", s_conflict_cnt, 4'd4);
    serve(1'b0, 1'b0, 32'h0000_0060, '0, {32{8'h22}}, 2, 1'b1, 1'b0);
    check("t2_cnt_i", conflict_cnt, 16'd4);

    // Both held for six transfers: D,I,D,I,D,I
    i_read    = 1'b1;
    i_address = 32'h0000_0080;
    d_read    = 1'b1;
    d_address = 32'h0000_0140;
    for (int n = 0; n < 6; n++) begin
      serve((n % 2) == 0, 1'b0, ((n % 2) == 0) ? 32'h0000_0140 : 32'h0000_0080, '0,
            {8{32'hC000_0000 + n}}, 1, 1'b0, 1'b0);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    check("t3_cnt", conflict_cnt, 16'd16);
    check("t3_sat", s_conflict_cnt, 4'd15);
    @(negedge clk);
    check("t3_idle", {pmem_read, pmem_write}, 2'b00);

    // Address change after grant is ignored; spurious response in IDLE
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    serve(1'b1, 1'b0, 32'h0000_0200, '0, {32{8'h5A}}, 3, 1'b1, 1'b1);
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("spur_resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("spur_strobes", {pmem_read, pmem_write}, 2'b00);
    check("t4_sat_hold", s_conflict_cnt, 4'd15);

    // Reset in the middle of an icache transfer
    i_read    = 1'b1;
    i_address = 32'h0000_0300;
    d_write   = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!pmem_read && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("t5_granted_i", pmem_read, 1'b1);
    @(posedge clk); #1;
    rst     = 1'b0;
    i_read  = 1'b0;
    d_write = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_strobes", {pmem_read, pmem_write}, 2'b00);
    check("t5_state", dut.state_q, IDLE);
    check("t5_cnt", conflict_cnt, 16'd0);
    check("t5_sat", s_conflict_cnt, 4'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    check("t5_late_resp", {i_resp, d_resp}, 2'b00);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("t5_after", {pmem_read, pmem_write}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
